// File: rtl/tag_lookup_ctrl.sv
// Two-way set-associative tag store with lookup FSM and memory miss/fill handshake.
// Latency: hit response 2 cycles after acceptance; miss response 1 cycle after the mem_ack edge.
// Backpressure: req_ready only in IDLE (one request in flight); mem_req held until mem_ack.
//
// Ports:
//   clk, rst                 sole clock, synchronous active-high reset
//   req_valid/req_ready      lookup request handshake, req_addr = {tag, index}
//   resp_valid/hit/way       one-cycle result pulse, hit flag and way hit or filled
//   way_sel                  registered way select for the downstream bank mux SEL
//   mem_req/mem_ack/mem_tag  fill request to memory, completion, tag being fetched
//
// Optional feature: define TAG_LRU_EN for a per-set LRU replacement bit; otherwise a
// single global round-robin bit picks the victim when both ways are valid.

module tag_lookup_ctrl #(
  parameter int TAG_W = 14,
  parameter int IDX_W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [TAG_W+IDX_W-1:0] req_addr,
  output logic                   resp_valid,
  output logic                   resp_hit,
  output logic                   resp_way,
  output logic                   way_sel,
  output logic                   mem_req,
  input  logic                   mem_ack,
  output logic [TAG_W-1:0]       mem_tag
);

  localparam int SETS = 1 << IDX_W;
  localparam int AW   = TAG_W + IDX_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOOKUP,
    S_MISS,
    S_RESP
  } state_t;

  state_t              state_q, state_d;
  logic [AW-1:0]       addr_q, addr_d;
  logic                victim_q, victim_d;
  logic                resp_valid_q, resp_valid_d;
  logic                resp_hit_q, resp_hit_d;
  logic                resp_way_q, resp_way_d;
  logic                way_sel_q, way_sel_d;
  logic                mem_req_q, mem_req_d;
  logic [TAG_W-1:0]    mem_tag_q, mem_tag_d;
  logic [SETS-1:0]     valid0_q, valid0_d;
  logic [SETS-1:0]     valid1_q, valid1_d;
`ifdef TAG_LRU_EN
  // Per-set bit pointing at the least-recently-used way.
  logic [SETS-1:0]     lru_q, lru_d;
`else
  // Global round-robin victim pointer, consulted only when both ways are valid.
  logic                rr_q, rr_d;
`endif

  // Tag storage is not reset; the valid bits alone qualify it.
  logic [TAG_W-1:0]    tag0_q [SETS];
  logic [TAG_W-1:0]    tag1_q [SETS];

  logic [TAG_W-1:0]    cur_tag;
  logic [IDX_W-1:0]    cur_idx;
  logic                hit0, hit1;
  logic                both_valid;
  logic                policy_way;
  logic                victim_sel;
  logic                fill_we;

  assign cur_tag = addr_q[AW-1:IDX_W];
  assign cur_idx = addr_q[IDX_W-1:0];

  assign hit0       = valid0_q[cur_idx] && (tag0_q[cur_idx] == cur_tag);
  assign hit1       = valid1_q[cur_idx] && (tag1_q[cur_idx] == cur_tag);
  assign both_valid = valid0_q[cur_idx] && valid1_q[cur_idx];

`ifdef TAG_LRU_EN
  assign policy_way = lru_q[cur_idx];
`else
  assign policy_way = rr_q;
`endif

  // Invalid ways are filled first (way 0 preferred); the policy only breaks ties
  // when the set is full.
  assign victim_sel = !valid0_q[cur_idx] ? 1'b0 :
                      !valid1_q[cur_idx] ? 1'b1 : policy_way;

  // Combinational so it drops in the reset cycle itself and rises in the first
  // cycle after reset, when the FSM is already in IDLE.
  assign req_ready = (state_q == S_IDLE) && !rst;

  assign resp_valid = resp_valid_q;
  assign resp_hit   = resp_hit_q;
  assign resp_way   = resp_way_q;
  assign way_sel    = way_sel_q;
  assign mem_req    = mem_req_q;
  assign mem_tag    = mem_tag_q;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    victim_d     = victim_q;
    resp_valid_d = 1'b0;
    resp_hit_d   = resp_hit_q;
    resp_way_d   = resp_way_q;
    way_sel_d    = way_sel_q;
    mem_req_d    = mem_req_q;
    mem_tag_d    = mem_tag_q;
    valid0_d     = valid0_q;
    valid1_d     = valid1_q;
    fill_we      = 1'b0;
`ifdef TAG_LRU_EN
    lru_d        = lru_q;
`else
    rr_d         = rr_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          state_d = S_LOOKUP;
        end
      end

      S_LOOKUP: begin
        if (hit0 || hit1) begin
          // Double match is not expected; way 0 wins if it happens.
          resp_valid_d = 1'b1;
          resp_hit_d   = 1'b1;
          resp_way_d   = !hit0;
          way_sel_d    = !hit0;
          state_d      = S_RESP;
`ifdef TAG_LRU_EN
          lru_d[cur_idx] = hit0;
`endif
        end else begin
          victim_d  = victim_sel;
          mem_tag_d = cur_tag;
          mem_req_d = 1'b1;
          state_d   = S_MISS;
        end
      end

      S_MISS: begin
        if (mem_ack) begin
          fill_we      = 1'b1;
          mem_req_d    = 1'b0;
          resp_valid_d = 1'b1;
          resp_hit_d   = 1'b0;
          resp_way_d   = victim_q;
          way_sel_d    = victim_q;
          state_d      = S_RESP;
          if (victim_q) valid1_d[cur_idx] = 1'b1;
          else          valid0_d[cur_idx] = 1'b1;
`ifdef TAG_LRU_EN
          lru_d[cur_idx] = !victim_q;
`else
          // Valid bits cannot change between LOOKUP and here, so a full set
          // means the victim came from the round-robin pointer.
          if (both_valid) rr_d = !rr_q;
`endif
        end
      end

      S_RESP: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      victim_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_hit_q   <= 1'b0;
      resp_way_q   <= 1'b0;
      way_sel_q    <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_tag_q    <= '0;
      valid0_q     <= '0;
      valid1_q     <= '0;
`ifdef TAG_LRU_EN
      lru_q        <= '0;
`else
      rr_q         <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      victim_q     <= victim_d;
      resp_valid_q <= resp_valid_d;
      resp_hit_q   <= resp_hit_d;
      resp_way_q   <= resp_way_d;
      way_sel_q    <= way_sel_d;
      mem_req_q    <= mem_req_d;
      mem_tag_q    <= mem_tag_d;
      valid0_q     <= valid0_d;
      valid1_q     <= valid1_d;
`ifdef TAG_LRU_EN
      lru_q        <= lru_d;
`else
      rr_q         <= rr_d;
`endif
    end
  end

  // A fill coinciding with reset is abandoned.
  always_ff @(posedge clk) begin
    if (!rst && fill_we) begin
      if (victim_q) tag1_q[cur_idx] <= cur_tag;
      else          tag0_q[cur_idx] <= cur_tag;
    end
  end

endmodule

// File: tb/tb_tag_lookup_ctrl.sv
// Directed bench for tag_lookup_ctrl: reset, cold miss/hit, way fill, eviction,
// memory handshake corner cases and reset in the middle of a miss.
// Inputs driven and outputs sampled 1 time unit after the rising edge.

module tb_tag_lookup_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [17:0] req_addr;
  logic        resp_valid;
  logic        resp_hit;
  logic        resp_way;
  logic        way_sel;
  logic        mem_req;
  logic        mem_ack;
  logic [13:0] mem_tag;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  tag_lookup_ctrl #(.TAG_W(14), .IDX_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .resp_valid (resp_valid),
    .resp_hit   (resp_hit),
    .resp_way   (resp_way),
    .way_sel    (way_sel),
    .mem_req    (mem_req),
    .mem_ack    (mem_ack),
    .mem_tag    (mem_tag)
  );

  // Issues one request from IDLE and services the miss handshake; returns what
  // was observed. ack_dly = number of mem_req-high cycles before mem_ack rises;
  // pre_ack holds mem_ack high through the IDLE and LOOKUP cycles.
  // lat counts cycles after acceptance until resp_valid is seen (40 = timeout).
  task automatic run_lookup(input logic [13:0] tag, input logic [3:0] idx,
                            input int ack_dly, input bit pre_ack,
                            output bit got, output logic hit, output logic way,
                            output logic wsel, output int lat, output int nreq,
                            output bit tag_bad, output logic vld_after,
                            output logic rdy_after);
    int cnt;
    got = 0; hit = 0; way = 0; wsel = 0; lat = 40; nreq = 0; tag_bad = 0;
    vld_after = 0; rdy_after = 0;
    cnt = ack_dly;
    req_addr  = {tag, idx};
    req_valid = 1'b1;
    mem_ack   = pre_ack;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int i = 1; i <= 40 && !got; i++) begin
      if (resp_valid) begin
        got = 1; lat = i; hit = resp_hit; way = resp_way; wsel = way_sel;
        mem_ack = 1'b0;
      end else begin
        mem_ack = pre_ack && (i == 1);
        if (mem_req) begin
          nreq++;
          if (mem_tag !== tag) tag_bad = 1;
          if (cnt == 0) mem_ack = 1'b1;
          else cnt--;
        end
        @(posedge clk); #1;
      end
    end
    mem_ack = 1'b0;
    if (got) begin
      @(posedge clk); #1;
      vld_after = resp_valid;
      rdy_after = req_ready;
    end
  endtask

  bit   g, tb;
  logic h, w, ws, va, ra;
  int   lt, nr;

  task automatic test_reset;
    rst = 1'b1; req_valid = 1'b0; mem_ack = 1'b0; req_addr = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++; if (resp_valid !== 1'b0) begin fails++; $display("FAIL rst_resp_valid: got %b exp 0", resp_valid); end
    checks++; if (resp_hit !== 1'b0) begin fails++; $display("FAIL rst_resp_hit: got %b exp 0", resp_hit); end
    checks++; if (resp_way !== 1'b0) begin fails++; $display("FAIL rst_resp_way: got %b exp 0", resp_way); end
    checks++; if (way_sel !== 1'b0) begin fails++; $display("FAIL rst_way_sel: got %b exp 0", way_sel); end
    checks++; if (mem_req !== 1'b0) begin fails++; $display("FAIL rst_mem_req: got %b exp 0", mem_req); end
    checks++; if (mem_tag !== 14'h0) begin fails++; $display("FAIL rst_mem_tag: got %h exp 0", mem_tag); end
    checks++; if (req_ready !== 1'b0) begin fails++; $display("FAIL rst_req_ready_in_reset: got %b exp 0", req_ready); end
    rst = 1'b0;
    #1;
    checks++; if (req_ready !== 1'b1) begin fails++; $display("FAIL rst_req_ready_after: got %b exp 1", req_ready); end
    run_lookup(14'h0000, 4'd0, 1, 0, g, h, w, ws, lt, nr, tb, va, ra);
    checks++; if (g !== 1'b1) begin fails++; $display("FAIL rst_lookup_resp: got %b exp 1", g); end
    checks++; if (h !== 1'b0) begin fails++; $display("FAIL rst_lookup_hit: got %b exp 0", h); end
    checks++; if (lt != 4) begin fails++; $display("FAIL rst_lookup_lat: got %0d exp 4", lt); end
  endtask

  task automatic test_cold_miss_hit;
    run_lookup(14'h1ABC, 4'd3, 4, 0, g, h, w, ws, lt, nr, tb, va, ra);
    checks++; if (g !== 1'b1) begin fails++; $display("FAIL cold_resp: got %b exp 1", g); end
    checks++; if (h !== 1'b0) begin fails++; $display("FAIL cold_hit: got %b exp 0", h); end
    checks++; if (w !== 1'b0) begin fails++; $display("FAIL cold_way: got %b exp 0", w); end
    checks++; if (ws !== 1'b0) begin fails++; $display("FAIL cold_way_sel: got %b exp 0", ws); end
    checks++; if (lt != 7) begin fails++; $display("FAIL cold_lat: got %0d exp 7", lt); end
    checks++; if (nr != 5) begin fails++; $display("FAIL cold_mem_req_cycles: got %0d exp 5", nr); end
    checks++; if (tb !== 1'b0) begin fails++; $display("FAIL cold_mem_tag_stable: got %b exp 0", tb); end
    checks++; if (va !== 1'b0) begin fails++; $display("FAIL cold_resp_pulse: got %b exp 0", va); end
    run_lookup(14'h1ABC, 4'd3, 0, 0, g, h, w, ws, lt, nr, tb, va, ra);
    checks++; if (h !== 1'b1) begin fails++; $display("FAIL rehit_hit: got %b exp 1", h); end
    checks++; if (w !== 1'b0) begin fails++; $display("FAIL rehit_way: got %b exp 0", w); end
    checks++; if (lt != 2) begin fails++; $display("FAIL rehit_lat: got %0d exp 2", lt); end
    checks++; if (nr != 0) begin fails++; $display("FAIL rehit_mem_req: got %0d exp 0", nr); end
    checks++; if (ra !== 1'b1) begin fails++; $display("FAIL rehit_ready_after: got %b exp 1", ra); end
  endtask

  task automatic test_second_way;
    run_lookup(14'h0123, 4'd3, 2, 0, g, h, w, ws, lt, nr, tb, va, ra);
    checks++; if (h !== 1'b0) begin fails++; $display("FAIL way1_hit: got %b exp 0", h); end
    checks++; if (w !== 1'b1) begin fails++; $display("FAIL way1_way: got %b exp 1", w); end
    checks++; if (ws !== 1'b1) begin fails++; $display("FAIL way1_way_sel: got %b exp 1", ws); end
    checks++; if (lt != 5) begin fails++; $display("FAIL way1_lat: got %0d exp 5", lt); end
    checks++; if (way_sel !== 1'b1) begin fails++; $display("FAIL way1_way_sel_hold: got %b exp 1", way_sel); end
  endtask

  task automatic test_eviction;
    logic exp_way_2000, exp_hit_1abc, exp_way_1abc, exp_way_0123;
`ifdef TAG_LRU_EN
    // Hit on way 0 leaves way 1 least recent; 0x1ABC re-hit keeps way 1 as victim.
    exp_way_2000 = 1'b1; exp_hit_1abc = 1'b1; exp_way_1abc = 1'b0; exp_way_0123 = 1'b1;
`else
    // Round-robin pointer starts at 0 and toggles after each full-set fill.
    exp_way_2000 = 1'b0; exp_hit_1abc = 1'b0; exp_way_1abc = 1'b1; exp_way_0123 = 1'b0;
`endif
    run_lookup(14'h1ABC, 4'd3, 0, 0, g, h, w, ws, lt, nr, tb, va, ra);
    checks++; if (h !== 1'b1) begin fails++; $display("FAIL evict_prehit_hit: got %b exp 1", h); end
    checks++; if (ws !== 1'b0) begin fails++; $display("FAIL evict_prehit_way_sel: got %b exp 0", ws); end
    run_lookup(14'h2000, 4'd3, 1, 0, g, h, w, ws, lt, nr, tb, va, ra);
    checks++; if (h !== 1'b0) begin fails++; $display("FAIL evict_2000_hit: got %b exp 0", h); end
    checks++; if (w !== exp_way_2000) begin fails++; $display("FAIL evict_2000_way: got %b exp %b", w, exp_way_2000); end
    run_lookup(14'h1ABC, 4'd3, 0, 0, g, h, w, ws, lt, nr, tb, va, ra);
    checks++; if (h !== exp_hit_1abc) begin fails++; $display("FAIL evict_1abc_hit: got %b exp %b", h, exp_hit_1abc); end
    checks++; if (w !== exp_way_1abc) begin fails++; $display("FAIL evict_1abc_way: got %b exp %b", w, exp_way_1abc); end
    run_lookup(14'h0123, 4'd3, 0, 0, g, h, w, ws, lt, nr, tb, va, ra);
    checks++; if (h !== 1'b0) begin fails++; $display("FAIL evict_0123_hit: got %b exp 0", h); end
    checks++; if (w !== exp_way_0123) begin fails++; $display("FAIL evict_0123_way: got %b exp %b", w, exp_way_0123); end
  endtask

  task automatic test_handshake;
    mem_ack = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++; if (mem_req !== 1'b0) begin fails++; $display("FAIL idle_ack_mem_req: got %b exp 0", mem_req); end
    checks++; if (resp_valid !== 1'b0) begin fails++; $display("FAIL idle_ack_resp_valid: got %b exp 0", resp_valid); end
    checks++; if (req_ready !== 1'b1) begin fails++; $display("FAIL idle_ack_ready: got %b exp 1", req_ready); end
    mem_ack = 1'b0;
    // Ack during IDLE/LOOKUP must not short-circuit the 3-cycle-delayed fill.
    run_lookup(14'h0555, 4'd5, 3, 1, g, h, w, ws, lt, nr, tb, va, ra);
    checks++; if (h !== 1'b0) begin fails++; $display("FAIL lookup_ack_hit: got %b exp 0", h); end
    checks++; if (lt != 6) begin fails++; $display("FAIL lookup_ack_lat: got %0d exp 6", lt); end
    checks++; if (nr != 4) begin fails++; $display("FAIL lookup_ack_mem_req_cycles: got %0d exp 4", nr); end
    checks++; if (tb !== 1'b0) begin fails++; $display("FAIL lookup_ack_mem_tag_stable: got %b exp 0", tb); end
    // mem_ack already high on MISS entry: single-cycle fill, max tag value.
    run_lookup(14'h3FFF, 4'd6, 0, 1, g, h, w, ws, lt, nr, tb, va, ra);
    checks++; if (h !== 1'b0) begin fails++; $display("FAIL zero_wait_hit: got %b exp 0", h); end
    checks++; if (w !== 1'b0) begin fails++; $display("FAIL zero_wait_way: got %b exp 0", w); end
    checks++; if (lt != 3) begin fails++; $display("FAIL zero_wait_lat: got %0d exp 3", lt); end
    checks++; if (nr != 1) begin fails++; $display("FAIL zero_wait_mem_req_cycles: got %0d exp 1", nr); end
  endtask

  task automatic test_back_to_back;
    run_lookup(14'h3FFF, 4'd6, 0, 0, g, h, w, ws, lt, nr, tb, va, ra);
    checks++; if (h !== 1'b1) begin fails++; $display("FAIL b2b_first_hit: got %b exp 1", h); end
    checks++; if (ra !== 1'b1) begin fails++; $display("FAIL b2b_ready: got %b exp 1", ra); end
    run_lookup(14'h0555, 4'd5, 0, 0, g, h, w, ws, lt, nr, tb, va, ra);
    checks++; if (h !== 1'b1) begin fails++; $display("FAIL b2b_second_hit: got %b exp 1", h); end
    checks++; if (lt != 2) begin fails++; $display("FAIL b2b_second_lat: got %0d exp 2", lt); end
  endtask

  task automatic test_reset_mid_miss;
    bit seen;
    seen = 0;
    req_addr = {14'h0AAA, 4'd9}; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (mem_req) seen = 1;
      else begin @(posedge clk); #1; end
    end
    checks++; if (seen !== 1'b1) begin fails++; $display("FAIL midmiss_mem_req_seen: got %b exp 1", seen); end
    rst = 1'b1; mem_ack = 1'b1;
    @(posedge clk); #1;
    checks++; if (mem_req !== 1'b0) begin fails++; $display("FAIL midmiss_mem_req_drop: got %b exp 0", mem_req); end
    checks++; if (resp_valid !== 1'b0) begin fails++; $display("FAIL midmiss_resp_valid: got %b exp 0", resp_valid); end
    checks++; if (req_ready !== 1'b0) begin fails++; $display("FAIL midmiss_ready_in_reset: got %b exp 0", req_ready); end
    rst = 1'b0; mem_ack = 1'b0;
    @(posedge clk); #1;
    checks++; if (resp_valid !== 1'b0) begin fails++; $display("FAIL midmiss_no_resp: got %b exp 0", resp_valid); end
    checks++; if (req_ready !== 1'b1) begin fails++; $display("FAIL midmiss_ready_after: got %b exp 1", req_ready); end
    run_lookup(14'h0AAA, 4'd9, 0, 0, g, h, w, ws, lt, nr, tb, va, ra);
    checks++; if (h !== 1'b0) begin fails++; $display("FAIL midmiss_abandoned_hit: got %b exp 0", h); end
    checks++; if (w !== 1'b0) begin fails++; $display("FAIL midmiss_abandoned_way: got %b exp 0", w); end
    run_lookup(14'h1ABC, 4'd3, 0, 0, g, h, w, ws, lt, nr, tb, va, ra);
    checks++; if (h !== 1'b0) begin fails++; $display("FAIL midmiss_valid_cleared: got %b exp 0", h); end
  endtask

  initial begin
    test_reset();
    test_cold_miss_hit();
    test_second_way();
    test_eviction();
    test_handshake();
    test_back_to_back();
    test_reset_mid_miss();
    $display("[TB] %0d tests run, %0d failed", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
